// File: rtl/ls161_cascade_capture.sv
// ---------------------------------------------------------------------------
// ls161_cascade_capture
//   Sits behind a 4-bit synchronous counter stage and extends its count to
//   TW = HI_W+4 bits by counting ripple-carry pulses in an upper counter.
//   A valid/ready capture port hands out a coherent snapshot of the full
//   count, and an edge-detected compare pulse flags when the count hits CMP.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active high, overrides everything
//   q_i            low nibble from the counter stage (its registered Q)
//   rco_i          carry pulse from the counter stage (q_i reads 0 then)
//   cnt_clr_i      synchronous clear of the upper count and overflow flag
//   cmp_i          compare value for match_o
//   cap_req_i      capture request
//   cap_ready_i    consumer ready
//   cap_valid_o    snapshot held and valid
//   cap_data_o     snapshot {upper, q_i}
//   cap_ovf_o      overflow flag belonging to the snapshot
//   cap_miss_o     sticky: a request was dropped while a snapshot was pending
//   hi_cnt_o       live upper count
//   ovf_o          sticky upper-counter overflow
//   match_o        one-cycle registered compare-match pulse
// ---------------------------------------------------------------------------
module ls161_cascade_capture #(
    parameter int HI_W = 12,
    localparam int TW  = HI_W + 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      q_i,
    input  logic            rco_i,
    input  logic            cnt_clr_i,
    input  logic [TW-1:0]   cmp_i,
    input  logic            cap_req_i,
    input  logic            cap_ready_i,
    output logic            cap_valid_o,
    output logic [TW-1:0]   cap_data_o,
    output logic            cap_ovf_o,
    output logic            cap_miss_o,
    output logic [HI_W-1:0] hi_cnt_o,
    output logic            ovf_o,
    output logic            match_o
);

    typedef enum logic {IDLE, HOLD} cap_state_t;

    cap_state_t      state_q;
    logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
    logic            ovf_q, ovf_d;
    logic [TW-1:0]   cap_data_q;
    logic            cap_ovf_q;
    logic            cap_miss_q;
    logic            match_q;
    logic [TW-1:0]   prev_full_q;

    logic [HI_W-1:0] hi_eff;
    logic [TW-1:0]   full;
    logic            ovf_eff;

    // The carry pulse arrives while q_i already reads 0, so the upper count
    // it belongs to is hi_cnt_q+1. Folding it in here keeps a snapshot taken
    // in a carry cycle coherent. A clear cycle presents the count as zero.
    always_comb begin
        hi_eff  = hi_cnt_q + {{(HI_W-1){1'b0}}, rco_i};
        full    = {hi_eff, q_i};
        ovf_eff = ovf_q | (rco_i & (&hi_cnt_q));
        if (cnt_clr_i) begin
            full    = '0;
            ovf_eff = 1'b0;
        end
    end

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        ovf_d    = ovf_q;
        if (cnt_clr_i) begin
            hi_cnt_d = '0;
            ovf_d    = 1'b0;
        end else if (rco_i) begin
            hi_cnt_d = hi_eff;      // wraps naturally at all-ones
            ovf_d    = ovf_eff;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hi_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            cap_data_q  <= '0;
            cap_ovf_q   <= 1'b0;
            cap_miss_q  <= 1'b0;
            match_q     <= 1'b0;
            prev_full_q <= '0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            ovf_q       <= ovf_d;
            prev_full_q <= full;
            // Fires only on arrival at CMP, not while the count stalls there.
            match_q     <= (full == cmp_i) && (prev_full_q != cmp_i);

            case (state_q)
                IDLE: begin
                    if (cap_req_i) begin
                        cap_data_q <= full;
                        cap_ovf_q  <= ovf_eff;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cap_ready_i) begin
                        // Handshake with a fresh request reloads without a
                        // valid gap; otherwise the port drains to IDLE.
                        if (cap_req_i) begin
                            cap_data_q <= full;
                            cap_ovf_q  <= ovf_eff;
                        end else begin
                            state_q    <= IDLE;
                        end
                    end else if (cap_req_i) begin
                        cap_miss_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_valid_o = (state_q == HOLD);
    assign cap_data_o  = cap_data_q;
    assign cap_ovf_o   = cap_ovf_q;
    assign cap_miss_o  = cap_miss_q;
    assign hi_cnt_o    = hi_cnt_q;
    assign ovf_o       = ovf_q;
    assign match_o     = match_q;

endmodule

// File: tb/tb_ls161_cascade_capture.sv
module tb_ls161_cascade_capture;

    localparam int HI_W = 12;
    localparam int TW   = HI_W + 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      q;
    logic            rco, cnt_clr, cap_req, cap_ready;
    logic [TW-1:0]   cmp;
    logic            cap_valid, cap_ovf, cap_miss, ovf, match;
    logic [TW-1:0]   cap_data;
    logic [HI_W-1:0] hi_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ls161_cascade_capture #(.HI_W(HI_W)) dut (
        .clk_i(clk), .rst_i(rst), .q_i(q), .rco_i(rco), .cnt_clr_i(cnt_clr),
        .cmp_i(cmp), .cap_req_i(cap_req), .cap_ready_i(cap_ready),
        .cap_valid_o(cap_valid), .cap_data_o(cap_data), .cap_ovf_o(cap_ovf),
        .cap_miss_o(cap_miss), .hi_cnt_o(hi_cnt), .ovf_o(ovf), .match_o(match)
    );

    // Advance one edge; outputs are read 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; q = 4'd0; rco = 1'b0; cnt_clr = 1'b0; cmp = '0;
        cap_req = 1'b0; cap_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (hi_cnt !== 12'h000) begin errors++; $display("FAIL reset_hi got %0h exp 0", hi_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
        checks++; if (cap_valid !== 1'b0 || cap_miss !== 1'b0 || cap_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_cap got v%0b m%0b o%0b exp 000", cap_valid, cap_miss, cap_ovf); end
        checks++; if (cap_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %0h exp 0", cap_data); end
        // CMP=0 with count at 0 straight from reset must not fire
        tick(); tick();
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_cmp0 got %0b exp 0", match); end
    endtask

    task automatic test_count();
        bit seen_match = 0;
        for (int i = 0; i < 16; i++) begin
            q = 4'(i); tick();
            if (match) seen_match = 1;
        end
        q = 4'd0; rco = 1'b1; tick();
        rco = 1'b0;
        checks++; if (hi_cnt !== 12'h001) begin errors++; $display("FAIL count_hi got %0h exp 1", hi_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL count_ovf got %0b exp 0", ovf); end
        for (int i = 1; i < 5; i++) begin
            q = 4'(i); tick();
            if (match) seen_match = 1;
        end
        checks++; if (seen_match !== 1'b0) begin errors++; $display("FAIL count_nomatch got %0b exp 0", seen_match); end
        q = 4'd5; cap_req = 1'b1;
        checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL cap_pre_valid got %0b exp 0", cap_valid); end
        tick();
        cap_req = 1'b0; q = 4'd6;
        checks++; if (cap_valid !== 1'b1) begin errors++; $display("FAIL cap_lat1_valid got %0b exp 1", cap_valid); end
        checks++; if (cap_data !== 16'h0015) begin errors++; $display("FAIL cap_data got %0h exp 0015", cap_data); end
        cap_ready = 1'b1; tick(); cap_ready = 1'b0;
        checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL cap_drain got %0b exp 0", cap_valid); end
    endtask

    task automatic test_carry_capture();
        q = 4'd0; rco = 1'b1; tick(); tick();       // hi 1 -> 3
        checks++; if (hi_cnt !== 12'h003) begin errors++; $display("FAIL carry_pre_hi got %0h exp 3", hi_cnt); end
        cap_req = 1'b1; tick();                      // carry and capture together
        rco = 1'b0; cap_req = 1'b0;
        checks++; if (cap_data !== 16'h0040) begin errors++; $display("FAIL carry_cap got %0h exp 0040", cap_data); end
        checks++; if (hi_cnt !== 12'h004) begin errors++; $display("FAIL carry_hi got %0h exp 4", hi_cnt); end
        cap_ready = 1'b1; tick(); cap_ready = 1'b0;
    endtask

    task automatic test_ovf_and_miss();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        checks++; if (hi_cnt !== 12'h000) begin errors++; $display("FAIL clr_hi got %0h exp 0", hi_cnt); end
        q = 4'd0; rco = 1'b1;
        for (int i = 0; i < 4095; i++) tick();
        rco = 1'b0; tick();
        checks++; if (hi_cnt !== 12'hFFF || ovf !== 1'b0) begin
            errors++; $display("FAIL pre_wrap got hi %0h ovf %0b exp fff 0", hi_cnt, ovf); end
        rco = 1'b1; cap_req = 1'b1; tick();
        rco = 1'b0; cap_req = 1'b0;
        checks++; if (hi_cnt !== 12'h000 || ovf !== 1'b1) begin
            errors++; $display("FAIL wrap got hi %0h ovf %0b exp 0 1", hi_cnt, ovf); end
        checks++; if (cap_data !== 16'h0000 || cap_ovf !== 1'b1 || cap_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_cap got d %0h o %0b v %0b exp 0 1 1", cap_data, cap_ovf, cap_valid); end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b exp 0", ovf); end
        checks++; if (cap_ovf !== 1'b1 || cap_valid !== 1'b1) begin
            errors++; $display("FAIL clr_keeps_cap got o %0b v %0b exp 1 1", cap_ovf, cap_valid); end
        // second request while pending and not ready -> dropped
        q = 4'd7; cap_req = 1'b1; tick();
        checks++; if (cap_data !== 16'h0000 || cap_miss !== 1'b1) begin
            errors++; $display("FAIL miss got d %0h m %0b exp 0 1", cap_data, cap_miss); end
        q = 4'd9; cap_ready = 1'b1; tick();          // handshake + reload
        cap_req = 1'b0;
        checks++; if (cap_valid !== 1'b1 || cap_data !== 16'h0009 || cap_ovf !== 1'b0) begin
            errors++; $display("FAIL b2b got v %0b d %0h o %0b exp 1 0009 0", cap_valid, cap_data, cap_ovf); end
        tick(); cap_ready = 1'b0;
        checks++; if (cap_valid !== 1'b0 || cap_miss !== 1'b1) begin
            errors++; $display("FAIL b2b_drain got v %0b m %0b exp 0 1", cap_valid, cap_miss); end
    endtask

    task automatic test_match();
        rst = 1'b1; tick(); rst = 1'b0;
        cmp = 16'h0023;
        q = 4'd0; rco = 1'b1; tick(); tick();        // hi 0 -> 2
        rco = 1'b0; q = 4'd2; tick();                 // full 0x22
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL match_early got %0b exp 0", match); end
        q = 4'd3; tick();                             // full 0x23 first seen
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL match_pulse got %0b exp 1", match); end
        tick();
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL match_hold1 got %0b exp 0", match); end
        tick();
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL match_hold2 got %0b exp 0", match); end
    endtask

    task automatic test_rst_in_hold();
        q = 4'd4; cap_req = 1'b1; tick();             // enter HOLD
        checks++; if (cap_valid !== 1'b1 || cap_data !== 16'h0024) begin
            errors++; $display("FAIL hold_setup got v %0b d %0h exp 1 0024", cap_valid, cap_data); end
        tick();                                       // sets miss
        rst = 1'b1; rco = 1'b1; q = 4'd5; tick();
        rst = 1'b0; rco = 1'b0; cap_req = 1'b0;
        checks++; if (hi_cnt !== 12'h000 || ovf !== 1'b0 || match !== 1'b0) begin
            errors++; $display("FAIL rst_hold_cnt got hi %0h ovf %0b m %0b exp 0 0 0", hi_cnt, ovf, match); end
        checks++; if (cap_valid !== 1'b0 || cap_data !== 16'h0000 || cap_ovf !== 1'b0 || cap_miss !== 1'b0) begin
            errors++; $display("FAIL rst_hold_cap got v %0b d %0h o %0b m %0b exp 0 0 0 0",
                               cap_valid, cap_data, cap_ovf, cap_miss); end
        q = 4'd6; cap_req = 1'b1; tick(); cap_req = 1'b0;
        checks++; if (cap_valid !== 1'b1 || cap_data !== 16'h0006 || cap_miss !== 1'b0) begin
            errors++; $display("FAIL rst_idle got v %0b d %0h m %0b exp 1 0006 0", cap_valid, cap_data, cap_miss); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry_capture();
        test_ovf_and_miss();
        test_match();
        test_rst_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
